// File: rtl/iir_pkg.sv
// ----------------------------------------------------------------------------
// iir_pkg
// Shared types and defaults for the IIR biquad control slice.
//   - iir_state_t    : control FSM states (IDLE, ISSUE, WAIT, UPDATE)
//   - iir_coef_sel_t : coefficient select codes used by the shadow write port
//   - IIR_DATA_W / IIR_COEF_W : default sample and coefficient widths
//   - IIR_NUM_COEF   : number of coefficients held per bank
// ----------------------------------------------------------------------------
package iir_pkg;

    localparam int IIR_DATA_W   = 16;
    localparam int IIR_COEF_W   = 18;
    localparam int IIR_NUM_COEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } iir_state_t;

    // Codes 5..7 are not listed and therefore never match a coefficient slot.
    typedef enum logic [2:0] {
        SEL_B1 = 3'd0,
        SEL_B2 = 3'd1,
        SEL_B3 = 3'd2,
        SEL_A2 = 3'd3,
        SEL_A3 = 3'd4
    } iir_coef_sel_t;

endpackage

// File: rtl/iir_coef_bank.sv
// ----------------------------------------------------------------------------
// iir_coef_bank
// Double-buffered coefficient storage for the biquad control path. Writes land
// in the shadow bank at any time; a commit raises 'pending', and the shadow
// bank is copied into the active bank in a cycle where the owner allows it
// (i_copy_en). A write and commit in the same cycle copy the freshly written
// value.
// Ports:
//   clk          clock
//   i_rst_n      synchronous active-low reset (both banks and pending -> 0)
//   i_we         shadow write enable
//   i_sel        coefficient select (0=b1,1=b2,2=b3,3=a2,4=a3; 5..7 ignored)
//   i_data       shadow write data
//   i_commit     request shadow -> active copy
//   i_copy_en    owner says a copy may happen at the end of this cycle
//   o_b1..o_a3   active coefficients
// ----------------------------------------------------------------------------
module iir_coef_bank
    import iir_pkg::*;
#(
    parameter int COEF_W = IIR_COEF_W
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [2:0]        i_sel,
    input  logic [COEF_W-1:0] i_data,
    input  logic              i_commit,
    input  logic              i_copy_en,
    output logic [COEF_W-1:0] o_b1,
    output logic [COEF_W-1:0] o_b2,
    output logic [COEF_W-1:0] o_b3,
    output logic [COEF_W-1:0] o_a2,
    output logic [COEF_W-1:0] o_a3
);

    logic              r_pending;
    logic              w_copy;
    logic [COEF_W-1:0] w_active [IIR_NUM_COEF];

    // A commit in the copy-enabled cycle itself takes effect immediately.
    assign w_copy = (r_pending || i_commit) && i_copy_en;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
        end else if (w_copy) begin
            r_pending <= 1'b0;
        end else if (i_commit) begin
            r_pending <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < IIR_NUM_COEF; gi++) begin : g_coef
            localparam iir_coef_sel_t LP_SEL = iir_coef_sel_t'(gi);

            logic [COEF_W-1:0] r_shadow;
            logic [COEF_W-1:0] r_active;
            logic [COEF_W-1:0] w_shadow_next;

            always_comb begin
                w_shadow_next = r_shadow;
                if (i_we && (i_sel == LP_SEL)) begin
                    w_shadow_next = i_data;
                end
            end

            // Copy from the next shadow value so same-cycle write+commit
            // carries the new data into the active bank.
            always_ff @(posedge clk) begin
                if (!i_rst_n) begin
                    r_shadow <= '0;
                    r_active <= '0;
                end else begin
                    r_shadow <= w_shadow_next;
                    if (w_copy) begin
                        r_active <= w_shadow_next;
                    end
                end
            end

            assign w_active[gi] = r_active;
        end
    endgenerate

    assign o_b1 = w_active[0];
    assign o_b2 = w_active[1];
    assign o_b3 = w_active[2];
    assign o_a2 = w_active[3];
    assign o_a3 = w_active[4];

endmodule

// File: rtl/iir_feedback_ctrl.sv
// ----------------------------------------------------------------------------
// iir_feedback_ctrl
// Control-side partner of the IIR biquad core. Accepts one sample at a time,
// presents it to the core together with y[n-1], y[n-2] and the active
// coefficients, waits (bounded by TIMEOUT) for the core result and then
// shifts the result into the output history.
//
// Optional feature macro: IIR_CLIP_DETECT_EN
//   defined   : o_clip_cnt counts UPDATE cycles whose result is full-scale
//               (+max or -min of DATA_W), saturating at 0xFFFF.
//   undefined : o_clip_cnt is tied to 0.
//
// Ports:
//   clk, i_rst_n             clock, synchronous active-low reset
//   i_valid, i_sample        input sample strobe and data
//   o_ready                  high only in IDLE
//   i_clear                  flush history, flags and clip counter (priority)
//   i_coef_we/sel/data       shadow coefficient write
//   i_coef_commit            request shadow -> active copy
//   o_iir_valid              one-cycle issue pulse to the core
//   o_iir_audio_in, o_iir_y1, o_iir_y2   operands held from ISSUE to UPDATE
//   o_b1..o_a3               active coefficients
//   i_iir_out, i_iir_valid   core result and strobe
//   o_sample, o_valid        filtered sample and one-cycle strobe
//   o_overrun                sticky: sample offered while busy
//   o_err                    sticky: core did not answer in time
//   o_clip_cnt               clip counter (see macro above)
// ----------------------------------------------------------------------------
module iir_feedback_ctrl
    import iir_pkg::*;
#(
    parameter int COEF_W  = IIR_COEF_W,
    parameter int DATA_W  = IIR_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_sample,
    output logic              o_ready,
    input  logic              i_clear,
    input  logic              i_coef_we,
    input  logic [2:0]        i_coef_sel,
    input  logic [COEF_W-1:0] i_coef_data,
    input  logic              i_coef_commit,
    output logic              o_iir_valid,
    output logic [DATA_W-1:0] o_iir_audio_in,
    output logic [DATA_W-1:0] o_iir_y1,
    output logic [DATA_W-1:0] o_iir_y2,
    output logic [COEF_W-1:0] o_b1,
    output logic [COEF_W-1:0] o_b2,
    output logic [COEF_W-1:0] o_b3,
    output logic [COEF_W-1:0] o_a2,
    output logic [COEF_W-1:0] o_a3,
    input  logic [DATA_W-1:0] i_iir_out,
    input  logic              i_iir_valid,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_valid,
    output logic              o_overrun,
    output logic              o_err,
    output logic [15:0]       o_clip_cnt
);

    localparam int              CNT_W        = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LP_WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE   = CNT_W'(1);

    iir_state_t        r_state;
    iir_state_t        w_state_next;
    logic              w_accept;
    logic              w_capture;
    logic              w_timeout;
    logic              w_copy_en;

    logic [CNT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_capture;
    logic [DATA_W-1:0] r_y1;
    logic [DATA_W-1:0] r_y2;
    logic              r_overrun;
    logic              r_err;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A zero-latency core answers during the issue cycle itself.
                if (i_iir_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_UPDATE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result arriving in the last allowed cycle still wins.
                if (i_iir_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_UPDATE;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (i_clear) begin
            w_state_next = ST_IDLE;
            w_accept     = 1'b0;
            w_capture    = 1'b0;
            w_timeout    = 1'b0;
        end
    end

    // Active coefficients may only change while no operands are on the wire:
    // any IDLE cycle, the closing UPDATE cycle, or the abort cycle.
    assign w_copy_en = (r_state == ST_IDLE) || (r_state == ST_UPDATE) || w_timeout;

    // ------------------------------------------------------------------
    // State, operands, history and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_sample   <= '0;
            r_capture  <= '0;
            r_y1       <= '0;
            r_y2       <= '0;
            r_overrun  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            // Counts cycles spent in WAIT; restarts on every other state.
            r_wait_cnt <= (r_state == ST_WAIT) ? (r_wait_cnt + LP_CNT_ONE) : '0;

            if (w_accept) begin
                r_sample <= i_sample;
            end
            if (w_capture) begin
                r_capture <= i_iir_out;
            end

            if (i_clear) begin
                r_y1      <= '0;
                r_y2      <= '0;
                r_overrun <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                if (r_state == ST_UPDATE) begin
                    r_y2 <= r_y1;
                    r_y1 <= r_capture;
                end
                if (w_timeout) begin
                    r_y1  <= '0;
                    r_y2  <= '0;
                    r_err <= 1'b1;
                end
                if (i_valid && (r_state != ST_IDLE)) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Clip counter
    // ------------------------------------------------------------------
`ifdef IIR_CLIP_DETECT_EN
    localparam logic [DATA_W-1:0] LP_POS_FULL = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] LP_NEG_FULL = {1'b1, {(DATA_W-1){1'b0}}};

    logic [15:0] r_clip_cnt;
    logic        w_clip_hit;

    assign w_clip_hit = (r_state == ST_UPDATE) &&
                        ((r_capture == LP_POS_FULL) || (r_capture == LP_NEG_FULL));

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_clip_cnt <= '0;
        end else if (i_clear) begin
            r_clip_cnt <= '0;
        end else if (w_clip_hit && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end

    assign o_clip_cnt = r_clip_cnt;
`else
    assign o_clip_cnt = 16'd0;
`endif

    // ------------------------------------------------------------------
    // Coefficient storage
    // ------------------------------------------------------------------
    iir_coef_bank #(
        .COEF_W (COEF_W)
    ) u_coef_bank (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_we      (i_coef_we),
        .i_sel     (i_coef_sel),
        .i_data    (i_coef_data),
        .i_commit  (i_coef_commit),
        .i_copy_en (w_copy_en),
        .o_b1      (o_b1),
        .o_b2      (o_b2),
        .o_b3      (o_b3),
        .o_a2      (o_a2),
        .o_a3      (o_a3)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_ready        = (r_state == ST_IDLE);
    assign o_iir_valid    = (r_state == ST_ISSUE);
    assign o_valid        = (r_state == ST_UPDATE);
    assign o_iir_audio_in = r_sample;
    assign o_iir_y1       = r_y1;
    assign o_iir_y2       = r_y2;
    assign o_sample       = r_capture;
    assign o_overrun      = r_overrun;
    assign o_err          = r_err;

endmodule

// File: tb/tb_iir_feedback_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iir_feedback_ctrl
// Directed bench for iir_feedback_ctrl with a small behavioural core model
// (latency 3, results taken from a table). Expected values are hand-derived
// from the cycle behaviour: accept at cycle 0, issue at 1, o_valid at L+2.
// ----------------------------------------------------------------------------
module tb_iir_feedback_ctrl;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [15:0] i_sample;
    logic        o_ready;
    logic        i_clear;
    logic        i_coef_we;
    logic [2:0]  i_coef_sel;
    logic [17:0] i_coef_data;
    logic        i_coef_commit;
    logic        o_iir_valid;
    logic [15:0] o_iir_audio_in;
    logic [15:0] o_iir_y1;
    logic [15:0] o_iir_y2;
    logic [17:0] o_b1, o_b2, o_b3, o_a2, o_a3;
    logic [15:0] i_iir_out   = 16'd0;
    logic        i_iir_valid = 1'b0;
    logic [15:0] o_sample;
    logic        o_valid;
    logic        o_overrun;
    logic        o_err;
    logic [15:0] o_clip_cnt;

    always #5 clk = ~clk;

    iir_feedback_ctrl #(
        .COEF_W  (18),
        .DATA_W  (16),
        .TIMEOUT (8)
    ) dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .i_sample       (i_sample),
        .o_ready        (o_ready),
        .i_clear        (i_clear),
        .i_coef_we      (i_coef_we),
        .i_coef_sel     (i_coef_sel),
        .i_coef_data    (i_coef_data),
        .i_coef_commit  (i_coef_commit),
        .o_iir_valid    (o_iir_valid),
        .o_iir_audio_in (o_iir_audio_in),
        .o_iir_y1       (o_iir_y1),
        .o_iir_y2       (o_iir_y2),
        .o_b1           (o_b1),
        .o_b2           (o_b2),
        .o_b3           (o_b3),
        .o_a2           (o_a2),
        .o_a3           (o_a3),
        .i_iir_out      (i_iir_out),
        .i_iir_valid    (i_iir_valid),
        .o_sample       (o_sample),
        .o_valid        (o_valid),
        .o_overrun      (o_overrun),
        .o_err          (o_err),
        .o_clip_cnt     (o_clip_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural core model ----------------
    int          core_lat  = 3;
    bit          core_mute = 1'b0;
    logic [15:0] core_res [16];
    int          core_idx  = 0;
    int          core_cnt  = 0;
    logic [15:0] iss_y1, iss_y2;

    always @(negedge clk) begin
        i_iir_valid = 1'b0;
        if (!i_rst_n) begin
            core_cnt = 0;
        end else if (o_iir_valid) begin
            iss_y1 = o_iir_y1;
            iss_y2 = o_iir_y2;
            if (!core_mute) core_cnt = core_lat;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                i_iir_valid = 1'b1;
                i_iir_out   = core_res[core_idx[3:0]];
                core_idx    = (core_idx + 1) % 16;
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!o_ready && k < 50) begin
            tick();
            k++;
        end
        if (!o_ready) chk("ready_bound", 32'(o_ready), 1);
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    // Offer one sample from IDLE; returns accept-to-o_valid cycle count and
    // leaves time positioned in the o_valid cycle.
    task automatic send(input logic [15:0] s, output int lat);
        wait_ready();
        i_valid  = 1'b1;
        i_sample = s;
        tick();
        i_valid  = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
        $display("txn sample=%0d result=%0d latency=%0d y1_in=%0d y2_in=%0d",
                 $signed(s), $signed(o_sample), lat, $signed(iss_y1), $signed(iss_y2));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

    initial begin
        int lat;
        int iss_at [8];
        int n_iss;
        int k;
        int vcnt;
        logic last_err;

        for (int i = 0; i < 16; i++) core_res[i] = 16'd0;
        i_rst_n = 1'b0; i_valid = 1'b0; i_sample = 16'd0; i_clear = 1'b0;
        i_coef_we = 1'b0; i_coef_sel = 3'd0; i_coef_data = 18'd0; i_coef_commit = 1'b0;
        repeat (3) tick();

        // ---- reset state ----
        chk("rst_iir_valid", 32'(o_iir_valid), 0);
        chk("rst_valid",     32'(o_valid), 0);
        chk("rst_b1",        32'(o_b1), 0);
        chk("rst_err",       32'(o_err), 0);
        chk("rst_y1",        32'(o_iir_y1), 0);
        chk("rst_clip",      32'(o_clip_cnt), 0);
        i_rst_n = 1'b1;
        tick();
        chk("rst_ready",   32'(o_ready), 1);
        chk("rst_overrun", 32'(o_overrun), 0);

        // ---- T1: single sample, L=3, result 1000 ----
        core_res[0] = 16'd1000; core_idx = 0;
        i_valid = 1'b1; i_sample = 16'd10;
        tick();
        i_valid = 1'b0;
        chk("t1_issue",    32'(o_iir_valid), 1);
        chk("t1_audio",    32'(o_iir_audio_in), 10);
        chk("t1_ready_lo", 32'(o_ready), 0);
        lat = 1;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
        $display("txn sample=10 result=%0d latency=%0d", $signed(o_sample), lat);
        chk("t1_latency", lat, 5);
        chk("t1_sample",  32'(o_sample), 1000);
        tick();
        chk("t1_ready", 32'(o_ready), 1);
        chk("t1_valid_one_cycle", 32'(o_valid), 0);
        chk("t1_y1",    32'(o_iir_y1), 1000);
        chk("t1_y2",    32'(o_iir_y2), 0);

        // ---- T2: history shift with results 5, 10, 15 ----
        pulse_clear();
        chk("t2_clear_y1", 32'(o_iir_y1), 0);
        core_res[0] = 16'd5; core_res[1] = 16'd10; core_res[2] = 16'd15; core_idx = 0;
        send(16'd1, lat);
        chk("t2_res0", 32'(o_sample), 5);
        send(16'd2, lat);
        chk("t2_iss2_y1", 32'(iss_y1), 5);
        send(16'd3, lat);
        chk("t2_latency", lat, 5);
        chk("t2_iss3_y1", 32'(iss_y1), 10);
        chk("t2_iss3_y2", 32'(iss_y2), 5);
        tick();
        chk("t2_y1", 32'(o_iir_y1), 15);
        chk("t2_y2", 32'(o_iir_y2), 10);

        // ---- T3: i_valid held high ----
        pulse_clear();
        core_idx = 0;
        n_iss = 0;
        i_valid = 1'b1; i_sample = 16'd7;
        for (int c = 0; c < 21; c++) begin
            if (o_iir_valid && n_iss < 8) begin
                iss_at[n_iss] = c;
                n_iss++;
            end
            tick();
        end
        i_valid = 1'b0;
        chk("t3_n_issue", n_iss, 4);
        chk("t3_first",   iss_at[0], 1);
        chk("t3_gap1",    iss_at[1] - iss_at[0], 6);
        chk("t3_gap2",    iss_at[2] - iss_at[1], 6);
        chk("t3_overrun", 32'(o_overrun), 1);

        // ---- T4: coefficient commit while busy, and at accept ----
        wait_ready();
        pulse_clear();
        chk("t4_overrun_clr", 32'(o_overrun), 0);
        core_res[0] = 16'd111; core_res[1] = 16'd222; core_idx = 0;
        i_valid = 1'b1; i_sample = 16'd1;
        tick();                                  // ISSUE
        i_valid = 1'b0;
        tick();                                  // WAIT
        i_coef_we = 1'b1; i_coef_sel = 3'd0; i_coef_data = 18'd3; i_coef_commit = 1'b1;
        tick();
        i_coef_we = 1'b0; i_coef_commit = 1'b0;
        chk("t4_b1_wait",   32'(o_b1), 0);
        tick();
        chk("t4_b1_wait2",  32'(o_b1), 0);
        tick();
        chk("t4_upd_valid", 32'(o_valid), 1);
        chk("t4_b1_upd",    32'(o_b1), 0);
        tick();
        chk("t4_b1_after",  32'(o_b1), 3);
        // write + commit in the accept cycle
        i_valid = 1'b1; i_sample = 16'd2;
        i_coef_we = 1'b1; i_coef_sel = 3'd1; i_coef_data = 18'd7; i_coef_commit = 1'b1;
        tick();
        i_valid = 1'b0; i_coef_we = 1'b0; i_coef_commit = 1'b0;
        chk("t4_iss_valid", 32'(o_iir_valid), 1);
        chk("t4_iss_b2",    32'(o_b2), 7);
        chk("t4_iss_b1",    32'(o_b1), 3);
        wait_ready();
        // selects 5..7 must not touch any coefficient
        i_coef_we = 1'b1; i_coef_sel = 3'd5; i_coef_data = 18'd99; i_coef_commit = 1'b1;
        tick();
        i_coef_we = 1'b0; i_coef_commit = 1'b0;
        tick();
        chk("t4_sel5_b1", 32'(o_b1), 3);
        chk("t4_sel5_b2", 32'(o_b2), 7);
        chk("t4_sel5_b3", 32'(o_b3), 0);
        chk("t4_sel5_a3", 32'(o_a3), 0);
        chk("t4_hist_y1", 32'(o_iir_y1), 222);

        // ---- T5: core never answers, TIMEOUT=8 ----
        core_mute = 1'b1;
        i_valid = 1'b1; i_sample = 16'd4;
        tick();
        i_valid = 1'b0;
        k = 1; vcnt = 0; last_err = 1'b0;
        while (!o_ready && k < 40) begin
            if (o_valid) vcnt++;
            i_valid  = (k == 3);
            last_err = o_err;
            tick();
            k++;
        end
        i_valid = 1'b0;
        $display("txn sample=4 timeout after %0d cycles err=%0d", k, o_err);
        chk("t5_idle_cycle", k, 10);
        chk("t5_err_late",   32'(last_err), 0);
        chk("t5_err",        32'(o_err), 1);
        chk("t5_y1",         32'(o_iir_y1), 0);
        chk("t5_y2",         32'(o_iir_y2), 0);
        chk("t5_no_valid",   vcnt, 0);
        chk("t5_overrun",    32'(o_overrun), 1);
        core_mute = 1'b0;
        pulse_clear();
        chk("t5_clr_err",     32'(o_err), 0);
        chk("t5_clr_overrun", 32'(o_overrun), 0);
        chk("t5_clr_b1",      32'(o_b1), 3);

        // ---- T6: full-scale results ----
        core_res[0] = 16'h8000; core_res[1] = 16'h0000; core_res[2] = 16'h7FFF; core_idx = 0;
        send(16'd5, lat);
        send(16'd6, lat);
        send(16'd8, lat);
        chk("t6_res", 32'(o_sample), 32'h7FFF);
        tick();
        chk("t6_y1", 32'(o_iir_y1), 32'h7FFF);
        chk("t6_y2", 32'(o_iir_y2), 0);
`ifdef IIR_CLIP_DETECT_EN
        chk("t6_clip", 32'(o_clip_cnt), 2);
`else
        chk("t6_clip_off", 32'(o_clip_cnt), 0);
`endif
        pulse_clear();
        chk("t6_clip_clr", 32'(o_clip_cnt), 0);
        chk("t6_clr_b2",   32'(o_b2), 7);
        chk("t6_clr_y1",   32'(o_iir_y1), 0);

        // ---- T7: reset mid-operation ----
        core_res[0] = 16'd55; core_idx = 0;
        i_valid = 1'b1; i_sample = 16'd9;
        tick();
        i_valid = 1'b0;
        tick();                                  // WAIT
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_valid) vcnt++;
            tick();
        end
        chk("t7_no_valid", vcnt, 0);
        chk("t7_ready",    32'(o_ready), 1);
        chk("t7_b1",       32'(o_b1), 0);
        chk("t7_y1",       32'(o_iir_y1), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
